// File: rtl/bsg_wormhole_mem_traffic_gen.sv
// bsg_wormhole_mem_traffic_gen
// Memory test traffic generator on a wormhole link. For every block it
// writes a deterministic data pattern, waits for the write acknowledge, then
// reads the block back and compares each word. Data and protocol mismatches
// are counted with saturation, and the address of the first failing block is
// kept.
//
// Ports
//   clk_i, reset_n_i            clock, synchronous active-low reset
//   start_i                     launches a run from IDLE or DONE
//   base_addr_i, num_blocks_i,
//   seed_i, dest_cord_i         run configuration, latched on start
//   link_v_o/link_data_o/
//   link_ready_and_i            outgoing request flits
//   link_v_i/link_data_i/
//   link_ready_and_o            incoming response flits
//   busy_o, done_o              run in progress / sticky run complete
//   error_count_o               saturating mismatch count
//   first_error_addr_o          block address of the first mismatch
module bsg_wormhole_mem_traffic_gen #(
    parameter int flit_width_p  = 32,
    parameter int cord_width_p  = 7,
    parameter int len_width_p   = 4,
    parameter int cid_width_p   = 4,
    parameter int cid_p         = 0,
    parameter int block_words_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic [flit_width_p-1:0] base_addr_i,
    input  logic [15:0]             num_blocks_i,
    input  logic [flit_width_p-1:0] seed_i,
    input  logic [cord_width_p-1:0] dest_cord_i,
    output logic                    link_v_o,
    output logic [flit_width_p-1:0] link_data_o,
    input  logic                    link_ready_and_i,
    input  logic                    link_v_i,
    input  logic [flit_width_p-1:0] link_data_i,
    output logic                    link_ready_and_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             error_count_o,
    output logic [flit_width_p-1:0] first_error_addr_o
);

    localparam int len_lsb_lp = cord_width_p;
    localparam int cid_lsb_lp = cord_width_p + len_width_p;
    localparam int wr_bit_lp  = cid_lsb_lp + cid_width_p;

    localparam logic [len_width_p-1:0]  bw_len_lp   = len_width_p'(block_words_p);
    localparam logic [len_width_p-1:0]  wr_len_lp   = len_width_p'(block_words_p + 1);
    localparam logic [len_width_p-1:0]  last_wd_lp  = len_width_p'(block_words_p - 1);
    localparam logic [len_width_p-1:0]  one_len_lp  = len_width_p'(1);
    localparam logic [cid_width_p-1:0]  cid_lp      = cid_width_p'(cid_p);
    localparam logic [flit_width_p-1:0] stride_lp   = flit_width_p'(block_words_p * (flit_width_p / 8));

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        WR_HDR      = 4'd1,
        WR_ADDR     = 4'd2,
        WR_DATA     = 4'd3,
        WR_RESP     = 4'd4,
        RD_HDR      = 4'd5,
        RD_ADDR     = 4'd6,
        RD_RESP_HDR = 4'd7,
        RD_DATA     = 4'd8,
        DONE        = 4'd9
    } state_e;

    // Request header: cord, len, own cid, write bit, zero padding above.
    function automatic logic [flit_width_p-1:0] make_hdr(
        input logic [cord_width_p-1:0] cord,
        input logic [len_width_p-1:0]  len,
        input logic                    wr
    );
        logic [flit_width_p-1:0] h;
        h = '0;
        h[cord_width_p-1:0]             = cord;
        h[len_lsb_lp +: len_width_p]    = len;
        h[cid_lsb_lp +: cid_width_p]    = cid_lp;
        h[wr_bit_lp]                    = wr;
        return h;
    endfunction

    state_e                  state_r, state_s;
    logic [15:0]             blk_r, blk_s, num_r, num_s, err_cnt_r, err_cnt_s;
    logic [len_width_p-1:0]  word_r, word_s, rsp_len_r, rsp_len_s;
    logic                    body_r, body_s;
    logic [flit_width_p-1:0] addr_r, addr_s, seed_r, seed_s, first_err_r, first_err_s;
    logic [cord_width_p-1:0] cord_r, cord_s;
    logic                    link_v_r, link_rdy_r, busy_r, done_r;
    logic [flit_width_p-1:0] link_data_r, data_s;
    logic                    tx_fire_s, rx_fire_s, err_inc_s, blk_end_s;
    logic [len_width_p-1:0]  rx_len_s;
    logic [cid_width_p-1:0]  rx_cid_s;
    logic                    rx_wr_s;

    // Next-state, run bookkeeping, error accounting and next request flit.
    always_comb begin
        state_s     = state_r;
        blk_s       = blk_r;
        num_s       = num_r;
        word_s      = word_r;
        rsp_len_s   = rsp_len_r;
        body_s      = body_r;
        addr_s      = addr_r;
        seed_s      = seed_r;
        cord_s      = cord_r;
        err_cnt_s   = err_cnt_r;
        first_err_s = first_err_r;
        err_inc_s   = 1'b0;
        blk_end_s   = 1'b0;
        data_s      = '0;
        tx_fire_s   = link_v_r & link_ready_and_i;
        rx_fire_s   = link_v_i & link_rdy_r;
        rx_len_s    = link_data_i[len_lsb_lp +: len_width_p];
        rx_cid_s    = link_data_i[cid_lsb_lp +: cid_width_p];
        rx_wr_s     = link_data_i[wr_bit_lp];

        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    num_s       = num_blocks_i;
                    addr_s      = base_addr_i;
                    seed_s      = seed_i;
                    cord_s      = dest_cord_i;
                    blk_s       = 16'd0;
                    word_s      = '0;
                    body_s      = 1'b0;
                    err_cnt_s   = 16'd0;
                    first_err_s = '0;
                    state_s     = (num_blocks_i == 16'd0) ? DONE : WR_HDR;
                end else begin
                    state_s = state_r;
                end
            end
            WR_HDR: begin
                if (tx_fire_s) state_s = WR_ADDR;
                else           state_s = state_r;
            end
            WR_ADDR: begin
                if (tx_fire_s) begin
                    state_s = WR_DATA;
                    word_s  = '0;
                end else begin
                    state_s = state_r;
                end
            end
            WR_DATA: begin
                if (tx_fire_s && word_r == last_wd_lp) begin
                    state_s = WR_RESP;
                    word_s  = '0;
                    body_s  = 1'b0;
                end else if (tx_fire_s) begin
                    word_s = word_r + one_len_lp;
                end else begin
                    state_s = state_r;
                end
            end
            WR_RESP: begin
                // After a malformed header, word_r counts the body flits still to drain.
                if (rx_fire_s && body_r) begin
                    if (word_r == one_len_lp) begin
                        state_s = RD_HDR;
                        body_s  = 1'b0;
                        word_s  = '0;
                    end else begin
                        word_s = word_r - one_len_lp;
                    end
                end else if (rx_fire_s) begin
                    err_inc_s = (rx_cid_s != cid_lp) || !rx_wr_s || (rx_len_s != '0);
                    if (rx_len_s != '0) begin
                        body_s = 1'b1;
                        word_s = rx_len_s;
                    end else begin
                        state_s = RD_HDR;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RD_HDR: begin
                if (tx_fire_s) state_s = RD_ADDR;
                else           state_s = state_r;
            end
            RD_ADDR: begin
                if (tx_fire_s) state_s = RD_RESP_HDR;
                else           state_s = state_r;
            end
            RD_RESP_HDR: begin
                if (rx_fire_s) begin
                    err_inc_s = (rx_cid_s != cid_lp) || rx_wr_s || (rx_len_s != bw_len_lp);
                    rsp_len_s = rx_len_s;
                    word_s    = '0;
                    if (rx_len_s == '0) blk_end_s = 1'b1;
                    else                state_s   = RD_DATA;
                end else begin
                    state_s = state_r;
                end
            end
            RD_DATA: begin
                if (rx_fire_s) begin
                    // Surplus flits of an over-long response are drained unchecked.
                    err_inc_s = (word_r < bw_len_lp) &&
                                (link_data_i != (seed_r ^ addr_r ^ flit_width_p'(word_r)));
                    if (word_r == rsp_len_r - one_len_lp) blk_end_s = 1'b1;
                    else                                  word_s    = word_r + one_len_lp;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (blk_end_s) begin
            word_s = '0;
            if (blk_r == num_r - 16'd1) begin
                state_s = DONE;
            end else begin
                state_s = WR_HDR;
                blk_s   = blk_r + 16'd1;
                addr_s  = addr_r + stride_lp;
            end
        end else begin
            blk_s = blk_s;
        end

        if (err_inc_s) begin
            if (err_cnt_r != 16'hFFFF) err_cnt_s = err_cnt_r + 16'd1;
            else                       err_cnt_s = err_cnt_r;
            if (err_cnt_r == 16'd0)    first_err_s = addr_r;
            else                       first_err_s = first_err_r;
        end else begin
            err_cnt_s = err_cnt_s;
        end

        // Flit presented after this edge; unchanged while the sender is stalled.
        case (state_s)
            WR_HDR:           data_s = make_hdr(cord_s, wr_len_lp, 1'b1);
            WR_ADDR, RD_ADDR: data_s = addr_s;
            WR_DATA:          data_s = seed_s ^ addr_s ^ flit_width_p'(word_s);
            RD_HDR:           data_s = make_hdr(cord_s, one_len_lp, 1'b0);
            default:          data_s = '0;
        endcase
    end

    // State, bookkeeping and registered outputs decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            blk_r       <= 16'd0;
            num_r       <= 16'd0;
            word_r      <= '0;
            rsp_len_r   <= '0;
            body_r      <= 1'b0;
            addr_r      <= '0;
            seed_r      <= '0;
            cord_r      <= '0;
            err_cnt_r   <= 16'd0;
            first_err_r <= '0;
            link_v_r    <= 1'b0;
            link_rdy_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            link_data_r <= '0;
        end else begin
            state_r     <= state_s;
            blk_r       <= blk_s;
            num_r       <= num_s;
            word_r      <= word_s;
            rsp_len_r   <= rsp_len_s;
            body_r      <= body_s;
            addr_r      <= addr_s;
            seed_r      <= seed_s;
            cord_r      <= cord_s;
            err_cnt_r   <= err_cnt_s;
            first_err_r <= first_err_s;
            link_v_r    <= state_s inside {WR_HDR, WR_ADDR, WR_DATA, RD_HDR, RD_ADDR};
            link_rdy_r  <= state_s inside {WR_RESP, RD_RESP_HDR, RD_DATA};
            busy_r      <= !(state_s inside {IDLE, DONE});
            done_r      <= (state_s == DONE);
            link_data_r <= data_s;
        end
    end

    assign link_v_o           = link_v_r;
    assign link_data_o        = link_data_r;
    assign link_ready_and_o   = link_rdy_r;
    assign busy_o             = busy_r;
    assign done_o             = done_r;
    assign error_count_o      = err_cnt_r;
    assign first_error_addr_o = first_err_r;

endmodule

// File: tb/tb_bsg_wormhole_mem_traffic_gen.sv
// Bench for bsg_wormhole_mem_traffic_gen: a behavioural memory (associative
// array) answers request packets, and every accepted request flit is compared
// against a sequence computed directly from the packet format rules.
module tb_bsg_wormhole_mem_traffic_gen;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = 32'd0;
    logic [15:0] num_blocks_i = 16'd0;
    logic [31:0] seed_i = 32'd0;
    logic [6:0]  dest_cord_i = 7'd0;
    logic        link_v_o;
    logic [31:0] link_data_o;
    logic        link_ready_and_i = 1'b0;
    logic        link_v_i = 1'b0;
    logic [31:0] link_data_i = 32'd0;
    logic        link_ready_and_o;
    logic        busy_o, done_o;
    logic [15:0] error_count_o;
    logic [31:0] first_error_addr_o;

    bsg_wormhole_mem_traffic_gen dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_blocks_i(num_blocks_i), .seed_i(seed_i),
        .dest_cord_i(dest_cord_i),
        .link_v_o(link_v_o), .link_data_o(link_data_o), .link_ready_and_i(link_ready_and_i),
        .link_v_i(link_v_i), .link_data_i(link_data_i), .link_ready_and_o(link_ready_and_o),
        .busy_o(busy_o), .done_o(done_o), .error_count_o(error_count_o),
        .first_error_addr_o(first_error_addr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] mem[logic [31:0]];
    int  req_cnt = 0, v_seen = 0, wr_pkts = 0, rd_pkts = 0;
    int  pk_rem = 0, pk_idx = 0;
    logic pk_wr = 1'b0, pk_hasaddr = 1'b0;
    logic [3:0]  pk_cid = 4'd0;
    logic [31:0] pk_addr = 32'd0;
    logic stall_en = 1'b0;
    int  corrupt_blk = -1, corrupt_word = 0, badcid_blk = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int cord, input int len, input int cid, input int wr);
        return 32'((wr << 15) | (cid << 11) | (len << 7) | cord);
    endfunction

    // Expected request stream: per block a write packet then a read packet.
    task automatic build_exp(input logic [31:0] base, input int n, input logic [31:0] seed,
                             input logic [6:0] cord);
        exp_q.delete();
        for (int b = 0; b < n; b++) begin
            logic [31:0] a;
            a = base + 32'(b * BW * 4);
            exp_q.push_back(hdr(int'(cord), 1 + BW, 0, 1));
            exp_q.push_back(a);
            for (int w = 0; w < BW; w++) exp_q.push_back(seed ^ a ^ 32'(w));
            exp_q.push_back(hdr(int'(cord), 1, 0, 0));
            exp_q.push_back(a);
        end
    endtask

    task automatic respond();
        logic [31:0] d;
        logic [3:0]  c;
        if (pk_wr) begin
            c = (wr_pkts == badcid_blk) ? (pk_cid ^ 4'h5) : pk_cid;
            rsp_q.push_back(hdr(0, 0, int'(c), 1));
            wr_pkts++;
        end else begin
            rsp_q.push_back(hdr(0, BW, int'(pk_cid), 0));
            for (int w = 0; w < BW; w++) begin
                d = mem.exists(pk_addr + 32'(w * 4)) ? mem[pk_addr + 32'(w * 4)] : 32'd0;
                if (rd_pkts == corrupt_blk && w == corrupt_word) d = d ^ 32'h0000_0100;
                rsp_q.push_back(d);
            end
            rd_pkts++;
        end
    endtask

    task automatic accept_req(input logic [31:0] f);
        check_eq("req_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("req_flit", f, exp_q.pop_front());
        req_cnt++;
        if (pk_rem == 0) begin
            pk_rem     = int'(f[10:7]);
            pk_wr      = f[15];
            pk_cid     = f[14:11];
            pk_hasaddr = 1'b0;
            pk_idx     = 0;
        end else begin
            if (!pk_hasaddr) begin
                pk_addr    = f;
                pk_hasaddr = 1'b1;
            end else begin
                mem[pk_addr + 32'(pk_idx * 4)] = f;
                pk_idx++;
            end
            pk_rem--;
            if (pk_rem == 0) respond();
        end
    endtask

    // Link agent: settles the handshakes of the last edge, then drives the next.
    initial begin : agent
        logic rst_rec, rv, rr, sv, sr;
        logic [31:0] rd;
        rst_rec = 1'b0; rv = 1'b0; rr = 1'b0; sv = 1'b0; sr = 1'b0; rd = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_rec) begin
                rsp_q.delete();
                pk_rem = 0;
            end else begin
                if (rv && rr) accept_req(rd);
                if (sv && sr) void'(rsp_q.pop_front());
            end
            if (link_v_o) v_seen++;
            link_ready_and_i = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
            if (rsp_q.size() > 0 && (!stall_en || $urandom_range(1, 0) == 1)) begin
                link_v_i    = 1'b1;
                link_data_i = rsp_q[0];
            end else begin
                link_v_i    = 1'b0;
                link_data_i = $urandom;
            end
            rst_rec = reset_n_i; rv = link_v_o; rr = link_ready_and_i; rd = link_data_o;
            sv = link_v_i; sr = link_ready_and_o;
        end
    end

    task automatic run(input logic [31:0] base, input int n, input logic [31:0] seed,
                       input logic [6:0] cord);
        build_exp(base, n, seed, cord);
        wr_pkts = 0; rd_pkts = 0; req_cnt = 0;
        @(posedge clk); #2;
        base_addr_i = base; num_blocks_i = 16'(n); seed_i = seed; dest_cord_i = cord;
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        base_addr_i = $urandom; seed_i = $urandom; dest_cord_i = 7'($urandom);
        num_blocks_i = 16'($urandom_range(9, 1));
    endtask

    task automatic finish_run(input string tag, input int n, input int exp_err,
                              input logic [31:0] exp_first);
        int cyc;
        cyc = 0;
        while (!done_o && cyc < 8000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_eq({tag, "_done"}, 32'(done_o), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_errs"}, 32'(error_count_o), 32'(exp_err));
        check_eq({tag, "_first"}, first_error_addr_o, exp_first);
        check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_wrpk"}, 32'(wr_pkts), 32'(n));
        check_eq({tag, "_rdpk"}, 32'(rd_pkts), 32'(n));
    endtask

    initial begin : main
        logic [31:0] b, s;
        int n, cyc;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_v", 32'(link_v_o), 32'd0);
        check_eq("rst_rdy", 32'(link_ready_and_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err", 32'(error_count_o), 32'd0);
        check_eq("rst_first", first_error_addr_o, 32'd0);
        check_eq("rst_data", link_data_o, 32'd0);
        reset_n_i = 1'b1;

        // Ideal memory, four blocks.
        run(32'h0000_1000, 4, 32'hA5A5_A5A5, 7'h15);
        check_eq("a_busy_start", 32'(busy_o), 32'd1);
        finish_run("a", 4, 0, 32'd0);

        // Zero blocks: DONE right after start, no request flits.
        v_seen = 0;
        run(32'h0000_4000, 0, 32'h1234_5678, 7'h02);
        check_eq("z_done", 32'(done_o), 32'd1);
        check_eq("z_busy", 32'(busy_o), 32'd0);
        repeat (4) @(posedge clk);
        #2;
        check_eq("z_vseen", 32'(v_seen), 32'd0);

        // Word 3 of block 2 corrupted on read.
        corrupt_blk = 2; corrupt_word = 3;
        run(32'h0000_2000, 4, 32'h0F0F_3C3C, 7'h07);
        check_eq("c_done_clr", 32'(done_o), 32'd0);
        finish_run("c", 4, 1, 32'h0000_2000 + 32'(2 * BW * 4));
        corrupt_blk = -1;

        // Bad cid on the write response of block 1; start from DONE clears results.
        badcid_blk = 1;
        run(32'h0000_3000, 3, 32'hDEAD_0001, 7'h33);
        check_eq("f_done_clr", 32'(done_o), 32'd0);
        check_eq("f_err_clr", 32'(error_count_o), 32'd0);
        check_eq("f_first_clr", first_error_addr_o, 32'd0);
        finish_run("f", 3, 1, 32'h0000_3000 + 32'(BW * 4));
        badcid_blk = -1;

        // Random stalls on both links, a stray start while busy.
        stall_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            b = $urandom; s = $urandom; n = $urandom_range(5, 2);
            run(b, n, s, 7'($urandom));
            repeat (20) @(posedge clk);
            #2;
            start_i = 1'b1;
            @(posedge clk); #2;
            start_i = 1'b0;
            finish_run("s", n, 0, 32'd0);
        end
        stall_en = 1'b0;

        // Reset while streaming write data, then a clean run.
        run(32'h0000_8000, 3, 32'h5555_AAAA, 7'h11);
        cyc = 0;
        while (req_cnt < 4 && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_eq("r_reached", 32'(req_cnt >= 4), 32'd1);
        reset_n_i = 1'b0;
        @(posedge clk); #2;
        check_eq("r_v", 32'(link_v_o), 32'd0);
        check_eq("r_rdy", 32'(link_ready_and_o), 32'd0);
        check_eq("r_busy", 32'(busy_o), 32'd0);
        check_eq("r_done", 32'(done_o), 32'd0);
        check_eq("r_data", link_data_o, 32'd0);
        reset_n_i = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        run(32'h0000_9000, 2, 32'h0BAD_CAFE, 7'h22);
        finish_run("r", 2, 0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_wormhole_mem_traffic_gen.md
BSG_WORMHOLE_MEM_TRAFFIC_GEN -- requirements
Module: bsg_wormhole_mem_traffic_gen

Interface
REQ-001 SHALL have parameter flit_width_p, default 32, meaning wormhole flit and data word width.
REQ-002 SHALL have parameter cord_width_p, default 7, meaning destination coordinate field width.
REQ-003 SHALL have parameter len_width_p, default 4, meaning packet length field width.
REQ-004 SHALL have parameter cid_width_p, default 4, meaning concentrator ID field width.
REQ-005 SHALL have parameter cid_p, default 0, meaning own concentrator ID placed in every request.
REQ-006 SHALL have parameter block_words_p, default 8, meaning data flits per block, range 1..(2**len_width_p)-2.
REQ-007 SHALL have the following ports:
  clk_i  in  1  sole clock
  reset_n_i  in  1  reset, synchronous, active-low
  start_i  in  1  pulse that launches a run when idle
  base_addr_i  in  flit_width_p  byte address of first block
  num_blocks_i  in  16  blocks to test, 0 allowed
  seed_i  in  flit_width_p  data pattern seed
  dest_cord_i  in  cord_width_p  memory target coordinate
  link_v_o / link_data_o / link_ready_and_i  out/out/in  1/flit_width_p/1  request flit stream
  link_v_i / link_data_i / link_ready_and_o  in/in/out  1/flit_width_p/1  response flit stream
  busy_o  out  1  run in progress
  done_o  out  1  sticky, set when run completes
  error_count_o  out  16  data plus protocol mismatches, saturating
  first_error_addr_o  out  flit_width_p  block address of first error

Function
REQ-008 Header flit SHALL be, LSB first: cord[cord_width_p], len[len_width_p], cid[cid_width_p], write bit, zero padding; len counts the flits that follow the header.
REQ-009 A write request SHALL be header(write=1, len=1+block_words_p), address flit, then block_words_p data flits.
REQ-010 A read request SHALL be header(write=0, len=1) followed by the address flit.
REQ-011 A write response SHALL be header only, len=0; a read response SHALL be header(len=block_words_p) followed by block_words_p data flits.
REQ-012 Data word w of block b SHALL be seed_i ^ addr_b ^ w, where addr_b = base_addr_i + b*block_words_p*(flit_width_p/8) modulo 2**flit_width_p.
REQ-013 FSM states SHALL be IDLE, WR_HDR, WR_ADDR, WR_DATA, WR_RESP, RD_HDR, RD_ADDR, RD_RESP_HDR, RD_DATA, DONE.
REQ-014 IDLE SHALL go to WR_HDR on start_i; it SHALL go directly to DONE if num_blocks_i=0. start_i SHALL latch base_addr_i, num_blocks_i, seed_i and dest_cord_i.
REQ-015 In the send states, link_v_o SHALL be 1 and the state SHALL advance only on the cycle link_v_o & link_ready_and_i is true, one flit per handshake; link_data_o SHALL hold steady while stalled.
REQ-016 In WR_RESP, RD_RESP_HDR and RD_DATA, link_ready_and_o SHALL be 1; in all other states it SHALL be 0. A flit SHALL be consumed on link_v_i & link_ready_and_o.
REQ-017 Per block, the sequence SHALL be: write, wait for write response, read, receive read data, compare. After block num_blocks_i-1, the FSM SHALL go to DONE; otherwise it SHALL go to WR_HDR of the next block.
REQ-018 A response header with wrong cid, wrong write bit, or wrong len SHALL count one protocol error; the FSM SHALL still consume len data flits before advancing.
REQ-019 Each read data flit unequal to its expected word SHALL count one error; error_count_o SHALL saturate at 16'hFFFF.
REQ-020 first_error_addr_o SHALL capture addr_b on the first error of a run and hold it thereafter.
REQ-021 DONE SHALL assert done_o; start_i in DONE SHALL clear done_o, error_count_o and first_error_addr_o, and begin a new run next cycle.
REQ-022 start_i SHALL be ignored while busy_o=1; busy_o SHALL be 1 in every state except IDLE and DONE.
REQ-023 An unsolicited response flit outside the receive states SHALL not be accepted; it stalls the sender.

Reset
REQ-024 While reset_n_i=0 at a clk_i edge, the FSM SHALL go to IDLE, and link_v_o, link_ready_and_o, busy_o and done_o SHALL be 0; error_count_o, first_error_addr_o and link_data_o SHALL be 0.
REQ-025 Reset mid-packet SHALL abandon the packet without emitting further flits; the memory side is reset together with this block.

Verification
REQ-026 Scenario: ideal memory, base=0x1000, num_blocks=4, seed=0xA5A5A5A5 -> 4 write and 4 read packets, done_o=1, error_count_o=0.
REQ-027 Scenario: num_blocks=0 -> DONE one cycle after start, link_v_o never 1.
REQ-028 Scenario: memory corrupts word 3 of block 2 -> error_count_o=1, first_error_addr_o=base+2*block_words_p*4.
REQ-029 Scenario: random link_ready_and_i and link_v_i stalls at 50% -> flit order and content unchanged, same result as the stall-free run.
REQ-030 Scenario: response header with wrong cid -> error_count_o increments by 1, the FSM completes, no hang.
REQ-031 Scenario: reset_n_i low during WR_DATA -> next cycle in IDLE with all outputs 0; a later start runs cleanly.
